aes_word_serializer_ctrl: RTL and testbench
===========================================

# aes_word_serializer_ctrl

Sequencing controller for the 128-to-32 output shift register of the AES-128 core. It accepts one 128-bit ciphertext block per valid/ready handshake and pulses the shift register's load input. It then steps the register with its shift input so the block leaves as four 32-bit words under a downstream valid/ready handshake, and it counts completed blocks. It sits between the cipher round datapath (upstream) and the 32-bit output bus (downstream); data itself flows only through the shift register.

## Interface

Parameters:
- WORDS, 4: words per block; fixed 128/32, other values unsupported.
- CNT_W, 16: width of the completed-block counter.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- blk_valid  in  1  upstream block present on shift-register data_in.
- blk_ready  out  1  controller can load a block this cycle.
- flush  in  1  synchronous abort of the block in flight.
- sr_load  out  1  to shift register load; captures data_in at this edge.
- sr_shift  out  1  to shift register shift_out; advances one word at this edge.
- word_valid  out  1  shift register data_out holds a valid word.
- word_ready  in  1  downstream accepts the word.
- word_last  out  1  current word is word WORDS-1 of its block.
- word_idx  out  2  index of current word, 0 = bits 127:96.
- busy  out  1  a block is in flight (state SEND).
- blk_count  out  CNT_W  blocks fully delivered since reset.

## Operation

- Shift register contract: after the sr_load edge, data_out = data_in[127:96]. Each sr_shift edge advances to the next lower 32 bits: [95:64], [63:32], [31:0].
- States: IDLE, SEND. Registers: state, idx (2b), blk_count.
- IDLE:
  - blk_ready=1; word_valid=0.
  - On blk_valid&blk_ready: sr_load=1, idx<=0, state<=SEND.
- SEND:
  - word_valid=1, word_idx=idx, word_last=(idx==WORDS-1), busy=1.
  - Accept = word_valid&word_ready.
  - Accept with !word_last: sr_shift=1, idx<=idx+1.
  - Accept with word_last: blk_count<=blk_count+1; state<=IDLE, or back-to-back reload (below).
- Back-to-back: in SEND, blk_ready=word_last&word_ready (combinational on word_ready). If blk_valid is also high: sr_load=1, idx<=0, state stays SEND.
- sr_load and sr_shift are never both 1; sr_shift is never 1 on the last word.
- Flush (any state) has priority:
  - Forces blk_ready, word_valid, sr_load and sr_shift to 0 that cycle.
  - Next state IDLE, idx<=0; blk_count unchanged; the partial block is dropped.
- blk_count wraps from 2^CNT_W-1 to 0.
- All outputs are combinational from state/idx plus the handshake inputs named above; no input-to-output path other than those listed.

## Timing

- While reset is high:
  - state=IDLE, idx=0, blk_count=0.
  - blk_ready, word_valid, word_last, sr_load, sr_shift, busy all 0 (blk_ready gated by reset).
  - word_idx=0.
- Reset deassertion: blk_ready=1 in the first cycle after release.
- Reset mid-block: block discarded, no count, no further sr_shift.
- Load latency: handshake at edge N; word 0 valid from cycle N+1.
- Throughput: with word_ready held high, one word per cycle; 4 cycles per block back-to-back with no idle cycle.
- Without overlap: last-word accept at edge M, IDLE in cycle M+1, next load no earlier than edge M+1.
- word_valid, once high, holds with a stable word_idx until accepted or flushed.

## Test plan

- Single block:
  - Stimulus: reset released, blk_valid=1 for one cycle with data_in=128'h0123456789ABCDEF0011223344556677, word_ready=1.
  - Response: sr_load pulses once; words 01234567, 89ABCDEF, 00112233, 44556677 on 4 consecutive cycles with word_idx 0..3; word_last only on the 4th; blk_count=1.
- Backpressure:
  - Stimulus: word_ready low for 3 cycles on word 1.
  - Response: word_valid held, word_idx=1, no sr_shift during the stall; sequence otherwise unchanged; blk_count=1.
- Back-to-back:
  - Stimulus: blk_valid held high for 3 blocks, word_ready=1.
  - Response: 12 words in 12 consecutive cycles; sr_load at the edges accepting words 3 and 7; sr_load never coincides with sr_shift; blk_count=3.
- Flush:
  - Stimulus: flush=1 during word 2 with word_ready=1.
  - Response: no accept that cycle; IDLE next cycle; blk_count unchanged; the next block starts at word_idx 0.
- Reset mid-block:
  - Stimulus: reset asserted asynchronously during word 1.
  - Response: all outputs 0 immediately; blk_count=0; after release, blk_ready=1 and a fresh block serializes correctly.
- Counter wrap:
  - Stimulus: CNT_W=2, deliver 5 blocks.
  - Response: blk_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/aes_word_serializer_ctrl.sv
// Load/shift sequencer for the AES-128 128-to-32 output shift register.
// Accepts one block per upstream handshake and delivers it as WORDS words downstream.
module aes_word_serializer_ctrl #(
    parameter int WORDS = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic             flush,
    output logic             sr_load,
    output logic             sr_shift,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             word_last,
    output logic [1:0]       word_idx,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [1:0] LAST_IDX = 2'(WORDS - 1);

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic       cnt_inc;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; all three are reset so no block survives a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            blk_count <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (cnt_inc)
                blk_count <= blk_count + CNT_W'(1);
        end
    end

    // NOTE: every output and next-state term gets a default first so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_inc    = 1'b0;
        blk_ready  = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        word_idx   = 2'd0;
        busy       = 1'b0;

        case (state)
            IDLE: begin
                // Held low while reset is asserted so nothing is offered a load.
                blk_ready = !flush && !reset;
                if (blk_valid && blk_ready) begin
                    sr_load   = 1'b1;
                    idx_nxt   = 2'd0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                busy       = 1'b1;
                word_idx   = idx;
                word_last  = (idx == LAST_IDX);
                word_valid = !flush;
                // Overlap the next load with acceptance of the final word.
                blk_ready  = word_last && word_ready && !flush;
                if (word_valid && word_ready) begin
                    if (!word_last) begin
                        sr_shift = 1'b1;
                        idx_nxt  = idx + 2'd1;
                    end else begin
                        cnt_inc = 1'b1;
                        idx_nxt = 2'd0;
                        if (blk_valid)
                            sr_load = 1'b1;
                        else
                            state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (flush) begin
            state_nxt = IDLE;
            idx_nxt   = 2'd0;
        end
    end

endmodule

// File: tb/tb_aes_word_serializer_ctrl.sv
// Scoreboard bench: a behavioural shift register turns controller pulses into words,
// expected words are queued at each block handshake and compared on each accept.
module tb_aes_word_serializer_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid, flush, word_ready;
    logic         blk_ready, sr_load, sr_shift, word_valid, word_last, busy;
    logic [1:0]   word_idx;
    logic [15:0]  blk_count;
    logic         blk_ready2, sr_load2, sr_shift2, word_valid2, word_last2, busy2;
    logic [1:0]   word_idx2;
    logic [1:0]   cnt2;
    logic [127:0] data_in;
    logic [127:0] sr_q;

    typedef struct packed {
        logic [31:0] w;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = '0;
    bit          cnt_pending = 1'b0;

    always #5 clk = ~clk;

    aes_word_serializer_ctrl #(.WORDS(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .flush(flush), .sr_load(sr_load), .sr_shift(sr_shift),
        .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last),
        .word_idx(word_idx), .busy(busy), .blk_count(blk_count)
    );

    aes_word_serializer_ctrl #(.WORDS(4), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready2),
        .flush(flush), .sr_load(sr_load2), .sr_shift(sr_shift2),
        .word_valid(word_valid2), .word_ready(word_ready), .word_last(word_last2),
        .word_idx(word_idx2), .busy(busy2), .blk_count(cnt2)
    );

    // External 128-to-32 shift register driven by the controller pulses.
    always @(posedge clk) begin
        if (sr_load)
            sr_q <= data_in;
        else if (sr_shift)
            sr_q <= {sr_q[95:0], 32'h0};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle, inputs are driven 1 time unit after posedge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            exp_cnt     = '0;
            cnt_pending = 1'b0;
        end else begin
            if (cnt_pending) begin
                check("blk_count", 32'(blk_count), 32'(exp_cnt));
                check("blk_count_w2", 32'(cnt2), 32'(exp_cnt[1:0]));
                cnt_pending = 1'b0;
            end
            check("load_shift_excl", 32'(sr_load && sr_shift), 32'd0);
            check("load_on_hs", 32'(sr_load), 32'(blk_valid && blk_ready));
            if (flush && busy)
                sb.delete();
            if (word_valid && word_ready) begin
                if (sb.size() == 0) begin
                    check("word_unexpected", 32'(word_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("word_data", sr_q[127:96], e.w);
                    check("word_idx", 32'(word_idx), 32'(e.idx));
                    check("word_last", 32'(word_last), 32'(e.last));
                    check("shift_on_accept", 32'(sr_shift), 32'(!e.last));
                    if (e.last) begin
                        exp_cnt     = exp_cnt + 16'd1;
                        cnt_pending = 1'b1;
                    end
                end
            end
            if (blk_valid && blk_ready) begin
                for (int k = 0; k < 4; k++) begin
                    e.w    = data_in[127 - 32*k -: 32];
                    e.idx  = 2'(k);
                    e.last = (k == 3);
                    sb.push_back(e);
                end
            end
        end
    end

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_blk_ready"}, 32'(blk_ready), 32'd0);
        check({tag, "_word_valid"}, 32'(word_valid), 32'd0);
        check({tag, "_word_last"}, 32'(word_last), 32'd0);
        check({tag, "_sr_load"}, 32'(sr_load), 32'd0);
        check({tag, "_sr_shift"}, 32'(sr_shift), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_word_idx"}, 32'(word_idx), 32'd0);
        check({tag, "_blk_count"}, 32'(blk_count), 32'd0);
        check({tag, "_cnt_w2"}, 32'(cnt2), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; blk_valid = 1'b0; word_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_all_zero("rst");
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 32'(blk_ready), 32'd1);
    endtask

    // Call with blk_valid already high; waits (bounded) for the load handshake.
    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = blk_ready;
        end
        check("load_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = !busy && (sb.size() == 0);
        end
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic send_block(input logic [127:0] d, input bit stall);
        bit ok;
        @(posedge clk); #1;
        data_in = d; blk_valid = 1'b1; word_ready = 1'b1;
        wait_load(ok);
        @(posedge clk); #1 blk_valid = 1'b0;
        if (ok && stall) begin
            @(posedge clk); #1 word_ready = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("stall_valid", 32'(word_valid), 32'd1);
                check("stall_idx", 32'(word_idx), 32'd1);
                check("stall_no_shift", 32'(sr_shift), 32'd0);
                @(posedge clk); #1;
            end
            word_ready = 1'b1;
        end
        wait_idle();
    endtask

    task automatic back_to_back();
        logic [127:0] b[3];
        bit ok;
        for (int k = 0; k < 3; k++) b[k] = rand_blk();
        @(posedge clk); #1;
        data_in = b[0]; blk_valid = 1'b1; word_ready = 1'b1;
        wait_load(ok);
        @(posedge clk); #1 data_in = b[1];
        if (ok) begin
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                check("b2b_valid", 32'(word_valid), 32'd1);
                check("b2b_idx", 32'(word_idx), 32'(i % 4));
                check("b2b_load", 32'(sr_load), 32'(i == 3 || i == 7));
                @(posedge clk); #1;
                if (i == 3) data_in = b[2];
                if (i == 7) blk_valid = 1'b0;
            end
        end
        blk_valid = 1'b0;
        wait_idle();
    endtask

    task automatic flush_test();
        logic [15:0] cnt_before;
        bit ok;
        cnt_before = exp_cnt;
        @(posedge clk); #1;
        data_in = rand_blk(); blk_valid = 1'b1; word_ready = 1'b1;
        wait_load(ok);
        @(posedge clk); #1 blk_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("flush_idx", 32'(word_idx), 32'd2);
        check("flush_valid", 32'(word_valid), 32'd0);
        check("flush_shift", 32'(sr_shift), 32'd0);
        check("flush_ready", 32'(blk_ready), 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_idle", 32'(busy), 32'd0);
        check("flush_ready_after", 32'(blk_ready), 32'd1);
        check("flush_count", 32'(blk_count), 32'(cnt_before));
        send_block(rand_blk(), 1'b0);
    endtask

    task automatic reset_mid_block();
        bit ok;
        @(posedge clk); #1;
        data_in = rand_blk(); blk_valid = 1'b1; word_ready = 1'b1;
        wait_load(ok);
        @(posedge clk); #1 blk_valid = 1'b0;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1 check_all_zero("rst_mid");
        word_ready = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(blk_ready), 32'd1);
        send_block(rand_blk(), 1'b0);
    endtask

    initial begin
        logic [1:0] wrap_exp[5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        reset = 1'b1; blk_valid = 1'b0; flush = 1'b0; word_ready = 1'b0;
        data_in = '0;

        do_reset();
        send_block(128'h0123456789ABCDEF0011223344556677, 1'b0);
        check("single_count", 32'(blk_count), 32'd1);

        send_block(rand_blk(), 1'b1);
        check("stall_count", 32'(blk_count), 32'd2);

        back_to_back();
        check("b2b_count", 32'(blk_count), 32'd5);

        flush_test();
        check("flush_total", 32'(blk_count), 32'd6);

        reset_mid_block();
        check("rst_mid_count", 32'(blk_count), 32'd1);

        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_block(rand_blk(), 1'b0);
            check("cnt_wrap", 32'(cnt2), 32'(wrap_exp[k]));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
